// File: rtl/xc_packet_pkg.sv
// Shared constants and state type for the correlation packet serializer.
package xc_packet_pkg;

    localparam logic [31:0] XC_HDR_MAGIC = 32'h41485021;
    localparam logic [31:0] XC_FTR_MAGIC = 32'h454E4421;
    localparam logic [7:0]  XC_CR        = 8'h0D;
    localparam logic [7:0]  XC_LF        = 8'h0A;

    typedef enum logic [2:0] {
        XC_IDLE,
        XC_HEADER,
        XC_PAYLOAD,
        XC_FOOTER,
        XC_EOL
    } xc_pkt_state_t;

endpackage

// File: rtl/xc_packet_serializer_if.sv
// Byte stream towards the UART transmitter: valid/ready handshake.
interface xc_packet_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/xc_nibble_to_ascii.sv
// Maps a 4-bit value to its upper-case ASCII hex digit.
module xc_nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) ascii = {4'h3, nibble};
        else                ascii = 8'h37 + {4'h0, nibble};
    end

endmodule

// File: rtl/xc_packet_serializer.sv
// Snapshots the correlation bus and streams it as a header/payload/footer packet.
// Define XC_PACKET_HEX_EN for ASCII-hex output with a trailing CR/LF.
//
// state      | meaning
// XC_IDLE    | waiting for start, tx_valid low
// XC_HEADER  | presenting header bytes (magic, seq, item count)
// XC_PAYLOAD | presenting captured bus, MSB first, accumulating csum
// XC_FOOTER  | presenting footer bytes (magic, csum)
// XC_EOL     | presenting CR then LF (hex build only)
module xc_packet_serializer
    import xc_packet_pkg::*;
#(
    parameter int NUM_BASELINES = 1,
    parameter int LAG_CROSS     = 1,
    parameter int RESOLUTION    = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic [NUM_BASELINES*(2*LAG_CROSS-1)*RESOLUTION*2-1:0] pulses,
    input  logic start,
    output logic busy,
    output logic clear_acc,
    xc_packet_serializer_if.master tx
);

    localparam int ITEMS        = NUM_BASELINES*(2*LAG_CROSS-1);
    localparam int PAYLOAD_BITS = ITEMS*RESOLUTION*2;
`ifdef XC_PACKET_HEX_EN
    localparam int NIB_PER_BYTE = 1;
`else
    localparam int NIB_PER_BYTE = 2;
`endif
    localparam int BW        = 4*NIB_PER_BYTE;
    localparam int HDR_BYTES = 16/NIB_PER_BYTE;
    localparam int PAY_BYTES = PAYLOAD_BITS/BW;
    localparam int CNT_W     = $clog2(PAY_BYTES + HDR_BYTES + 1);

    xc_pkt_state_t state, state_nxt;

    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [63:0]             seg_sr, seg_word;
    logic [PAYLOAD_BITS-1:0] pay_sr;
    logic [15:0]             csum, seq;
    logic [63:0]             hdr_word, ftr_word;
    logic [BW-1:0]           nib_bits;
    logic [7:0]              nib_byte, lit_byte, byte_nxt;
    logic                    capture, accept, last;
    logic                    byte_load, use_lit, seg_load, seg_shift, pay_shift, pkt_done;

    assign hdr_word = {XC_HDR_MAGIC, seq, 16'(ITEMS)};
    assign ftr_word = {XC_FTR_MAGIC, 16'h0000, csum};
    assign accept   = tx.tx_valid & tx.tx_ready;
    assign last     = (cnt == '0);
    assign capture  = (state == XC_IDLE) & start;

    function automatic logic [15:0] nib_sum(input logic [BW-1:0] b);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < NIB_PER_BYTE; i++) s = s + 16'(b[4*i +: 4]);
        return s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= XC_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            XC_IDLE:    if (start) state_nxt = XC_HEADER;
            XC_HEADER:  if (accept && last) state_nxt = XC_PAYLOAD;
            XC_PAYLOAD: if (accept && last) state_nxt = XC_FOOTER;
`ifdef XC_PACKET_HEX_EN
            XC_FOOTER:  if (accept && last) state_nxt = XC_EOL;
`else
            XC_FOOTER:  if (accept && last) state_nxt = XC_IDLE;
`endif
            XC_EOL:     if (accept && last) state_nxt = XC_IDLE;
            default:    state_nxt = XC_IDLE;
        endcase
    end

    // Each branch decides the byte that follows the one currently on tx_data.
    always_comb begin
        busy      = (state != XC_IDLE);
        byte_load = 1'b0;
        use_lit   = 1'b0;
        lit_byte  = '0;
        nib_bits  = '0;
        seg_load  = 1'b0;
        seg_word  = hdr_word;
        seg_shift = 1'b0;
        pay_shift = 1'b0;
        pkt_done  = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            XC_IDLE: if (start) begin
                byte_load = 1'b1;
                nib_bits  = hdr_word[63 -: BW];
                seg_load  = 1'b1;
                cnt_nxt   = CNT_W'(HDR_BYTES-1);
            end
            XC_HEADER: if (accept) begin
                byte_load = 1'b1;
                if (last) begin
                    nib_bits  = pay_sr[PAYLOAD_BITS-1 -: BW];
                    pay_shift = 1'b1;
                    cnt_nxt   = CNT_W'(PAY_BYTES-1);
                end else begin
                    nib_bits  = seg_sr[63 -: BW];
                    seg_shift = 1'b1;
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            XC_PAYLOAD: if (accept) begin
                byte_load = 1'b1;
                if (last) begin
                    seg_word = ftr_word;
                    seg_load = 1'b1;
                    nib_bits = ftr_word[63 -: BW];
                    cnt_nxt  = CNT_W'(HDR_BYTES-1);
                end else begin
                    nib_bits  = pay_sr[PAYLOAD_BITS-1 -: BW];
                    pay_shift = 1'b1;
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            XC_FOOTER: if (accept) begin
                if (last) begin
`ifdef XC_PACKET_HEX_EN
                    byte_load = 1'b1;
                    use_lit   = 1'b1;
                    lit_byte  = XC_CR;
                    cnt_nxt   = CNT_W'(1);
`else
                    pkt_done  = 1'b1;
`endif
                end else begin
                    byte_load = 1'b1;
                    nib_bits  = seg_sr[63 -: BW];
                    seg_shift = 1'b1;
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            XC_EOL: if (accept) begin
                if (last) begin
                    pkt_done = 1'b1;
                end else begin
                    byte_load = 1'b1;
                    use_lit   = 1'b1;
                    lit_byte  = XC_LF;
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

`ifdef XC_PACKET_HEX_EN
    xc_nibble_to_ascii u_nibble_to_ascii (
        .nibble (nib_bits),
        .ascii  (nib_byte)
    );
`else
    assign nib_byte = 8'(nib_bits);
`endif

    assign byte_nxt = use_lit ? lit_byte : nib_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            clear_acc   <= 1'b0;
            cnt         <= '0;
            seg_sr      <= '0;
            pay_sr      <= '0;
            csum        <= '0;
            seq         <= '0;
        end else begin
            clear_acc   <= capture;
            tx.tx_valid <= (state_nxt != XC_IDLE);
            cnt         <= cnt_nxt;
            if (byte_load) tx.tx_data <= byte_nxt;
            if (seg_load)       seg_sr <= seg_word << BW;
            else if (seg_shift) seg_sr <= seg_sr << BW;
            if (capture)        pay_sr <= pulses;
            else if (pay_shift) pay_sr <= pay_sr << BW;
            // csum covers each payload byte at the moment it is fetched
            if (capture)        csum <= '0;
            else if (pay_shift) csum <= csum + nib_sum(pay_sr[PAYLOAD_BITS-1 -: BW]);
            if (pkt_done) seq <= seq + 16'd1;
        end
    end

endmodule

// File: tb/tb_xc_packet_serializer.sv
// Directed bench for xc_packet_serializer; follows XC_PACKET_HEX_EN if defined.
module tb_xc_packet_serializer;

`ifdef XC_PACKET_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif
    localparam int HB = HEX ? 16 : 8;

    logic clk = 1'b0;
    logic reset;
    logic start_s, start_b;
    logic busy_s, clr_s, busy_b, clr_b;
    logic [15:0]  pulses_s;
    logic [191:0] pulses_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] bin_ref [18] = '{8'h41, 8'h48, 8'h50, 8'h21, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA5,
                                 8'hC3, 8'h45, 8'h4E, 8'h44, 8'h21, 8'h00, 8'h00, 8'h00, 8'h1E};
    logic [7:0] hdr_b_ref [8] = '{8'h41, 8'h48, 8'h50, 8'h21, 8'h00, 8'h00, 8'h00, 8'h04};

    always #5 clk = ~clk;

    xc_packet_serializer_if if_s ();
    xc_packet_serializer_if if_b ();

    xc_packet_serializer #(.NUM_BASELINES(1), .LAG_CROSS(1), .RESOLUTION(8)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .pulses    (pulses_s),
        .start     (start_s),
        .busy      (busy_s),
        .clear_acc (clr_s),
        .tx        (if_s)
    );

    xc_packet_serializer #(.NUM_BASELINES(4), .LAG_CROSS(1), .RESOLUTION(24)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .pulses    (pulses_b),
        .start     (start_b),
        .busy      (busy_b),
        .clear_acc (clr_b),
        .tx        (if_b)
    );

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input logic [15:0] sq);
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < 18; i++) begin
            b = (i == 4) ? sq[15:8] : (i == 5) ? sq[7:0] : bin_ref[i];
            if (HEX) begin
                exp_q.push_back(asc(b[7:4]));
                exp_q.push_back(asc(b[3:0]));
            end else begin
                exp_q.push_back(b);
            end
        end
        if (HEX) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Starts a packet on dut_s and consumes it; returns at the first idle cycle.
    task automatic send_pkt(input string tag, input logic [15:0] sq, input bit stall, input bit hold);
        int idx, cyc, n_clr;
        logic [7:0] held;
        bit was_stalled, rdy;
        build_exp(sq);
        start_s = 1'b1;
        if_s.tx_ready = 1'b1;
        @(negedge clk);
        if (!hold) start_s = 1'b0;
        check({tag, "/clear_acc_c1"}, 32'(clr_s), 32'd1);
        check({tag, "/busy_c1"}, 32'(busy_s), 32'd1);
        idx = 0; cyc = 0; n_clr = 0; was_stalled = 1'b0; held = '0;
        while (idx < exp_q.size() && cyc < 400) begin
            rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if_s.tx_ready = rdy;
            if (clr_s) n_clr++;
            check({tag, "/valid"}, 32'(if_s.tx_valid), 32'd1);
            if (was_stalled) check({tag, "/held"}, 32'(if_s.tx_data), 32'(held));
            if (rdy) begin
                check($sformatf("%s/byte%0d", tag, idx), 32'(if_s.tx_data), 32'(exp_q[idx]));
                idx++;
            end
            was_stalled = !rdy;
            held = if_s.tx_data;
            @(negedge clk);
            cyc++;
        end
        if_s.tx_ready = 1'b1;
        check({tag, "/len"}, 32'(idx), 32'(exp_q.size()));
        check({tag, "/clear_acc_count"}, 32'(n_clr), 32'd1);
        check({tag, "/valid_end"}, 32'(if_s.tx_valid), 32'd0);
        check({tag, "/busy_end"}, 32'(busy_s), 32'd0);
    endtask

    initial begin
        int k;
        logic [7:0] e;
        reset = 1'b1;
        start_s = 1'b0;
        start_b = 1'b0;
        if_s.tx_ready = 1'b0;
        if_b.tx_ready = 1'b0;
        pulses_s = 16'hA5C3;
        pulses_b = 192'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978;
        #12;
        check("rst/busy", 32'(busy_s), 32'd0);
        check("rst/clear_acc", 32'(clr_s), 32'd0);
        check("rst/valid", 32'(if_s.tx_valid), 32'd0);
        check("rst/data", 32'(if_s.tx_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send_pkt("p0", 16'h0000, 1'b0, 1'b0);
        send_pkt("p1_stall", 16'h0001, 1'b1, 1'b0);

        force dut_s.seq = 16'hFFFF;
        @(negedge clk);
        release dut_s.seq;
        send_pkt("p_ffff", 16'hFFFF, 1'b0, 1'b0);
        send_pkt("p_wrap", 16'h0000, 1'b0, 1'b0);

        send_pkt("hold_a", 16'h0001, 1'b0, 1'b1);
        send_pkt("hold_b", 16'h0002, 1'b0, 1'b1);
        start_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle/valid", 32'(if_s.tx_valid), 32'd0);
            check("idle/busy", 32'(busy_s), 32'd0);
        end

        // Large configuration: abort with reset at the 5th payload byte.
        if_b.tx_ready = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (k < HB + 4 && if_b.tx_valid) begin
            @(negedge clk);
            k++;
        end
        check("abort/reached", 32'(k), 32'(HB + 4));
        check("abort/valid_before", 32'(if_b.tx_valid), 32'd1);
        check("abort/pay5", 32'(if_b.tx_data), HEX ? 32'h34 : 32'h89);
        #2 reset = 1'b1;
        #1;
        check("abort/valid_async", 32'(if_b.tx_valid), 32'd0);
        check("abort/busy_async", 32'(busy_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < HB; i++) begin
            e = HEX ? asc((i % 2 == 0) ? hdr_b_ref[i/2][7:4] : hdr_b_ref[i/2][3:0]) : hdr_b_ref[i];
            check($sformatf("after_abort/hdr%0d", i), 32'(if_b.tx_data), 32'(e));
            @(negedge clk);
        end
        k = 0;
        while (if_b.tx_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("after_abort/busy_end", 32'(busy_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
